// File: rtl/hack_pkg.sv
// Shared types and defaults for the Hack boot controller: FSM state encoding,
// ROM address width and the host stop byte.
package hack_pkg;

  localparam int         ROM_AW_DEF    = 15;
  localparam logic [7:0] STOP_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_RUN,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/hack_boot_ctrl_if.sv
// Host byte stream plus the CPU/ROM control bundle owned by the boot controller.
// The slave side is the controller; the master side is the host/CPU environment.
interface hack_boot_ctrl_if import hack_pkg::*; #(
  parameter int ROM_AW = ROM_AW_DEF
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              rom_we;
  logic              cpu_reset;
  logic [ROM_AW-1:0] cpu_pc;

  modport master (
    output rx_data, rx_valid, cpu_pc,
    input  rx_ready, rom_addr, rom_wdata, rom_we, cpu_reset
  );

  modport slave (
    input  rx_data, rx_valid, cpu_pc,
    output rx_ready, rom_addr, rom_wdata, rom_we, cpu_reset
  );

endinterface

// File: rtl/hack_halt_detect.sv
// Detects a CPU spinning in a 1- or 2-instruction loop by comparing the pc
// against its value two cycles earlier; halt pulses on the final required match.
module hack_halt_detect #(
  parameter int ROM_AW      = 15,
  parameter int HALT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [ROM_AW-1:0] pc,
  output logic              halt
);

  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [ROM_AW-1:0] pcHist1_q, pcHist2_q;
  logic [1:0]        histCnt_q;
  logic [CNT_W-1:0]  matchCnt_q;
  logic              match;

  assign match = enable && (histCnt_q == 2'd2) && (pc == pcHist2_q);
  assign halt  = match && (matchCnt_q == CNT_W'(HALT_CYCLES - 1));

  // History only counts once two valid samples exist since the last clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcHist1_q  <= '0;
      pcHist2_q  <= '0;
      histCnt_q  <= '0;
      matchCnt_q <= '0;
    end else if (clear) begin
      pcHist1_q  <= '0;
      pcHist2_q  <= '0;
      histCnt_q  <= '0;
      matchCnt_q <= '0;
    end else if (enable) begin
      pcHist1_q <= pc;
      pcHist2_q <= pcHist1_q;
      if (histCnt_q != 2'd2) histCnt_q <= histCnt_q + 2'd1;
      if (!match)    matchCnt_q <= '0;
      else if (!halt) matchCnt_q <= matchCnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed program from the host byte stream into
// instruction ROM, runs the CPU, and returns it to reset on halt or stop byte.
module hack_boot_ctrl import hack_pkg::*; #(
  parameter int         ROM_AW      = ROM_AW_DEF,
  parameter int         HALT_CYCLES = 4,
  parameter logic [7:0] STOP_BYTE   = STOP_BYTE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hack_boot_ctrl_if.slave  bus,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [31:0]      cycle_count
);

  state_e            state_q, state_d;
  logic [7:0]        lenHi_q, lenHi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        dataHi_q, dataHi_d;
  logic [16:0]       wordIdx_q, wordIdx_d;
  logic [ROM_AW-1:0] romAddr_q, romAddr_d;
  logic [15:0]       romWdata_q, romWdata_d;
  logic              romWe_q, romWe_d;
  logic              cpuReset_q, cpuReset_d;
  logic              err_q, err_d;
  logic              halted_q, halted_d;
  logic [31:0]       cycleCount_q, cycleCount_d;

  logic        accept, lenBad, lastWord, haltDet, haltClear;
  logic [15:0] newLen;
  logic [16:0] wordNext;

  assign bus.rx_ready = 1'b1;
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign newLen       = {lenHi_q, bus.rx_data};
  assign lenBad       = (newLen == 16'd0) || ({16'd0, newLen} > (32'd1 << ROM_AW));
  assign wordNext     = wordIdx_q + 17'd1;
  assign lastWord     = (wordNext == {1'b0, len_q});

  hack_halt_detect #(
    .ROM_AW      (ROM_AW),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RUN),
    .clear  (haltClear),
    .pc     (bus.cpu_pc),
    .halt   (haltDet)
  );

  always_comb begin
    state_d      = state_q;
    lenHi_d      = lenHi_q;
    len_d        = len_q;
    dataHi_d     = dataHi_q;
    wordIdx_d    = wordIdx_q;
    romAddr_d    = romAddr_q;
    romWdata_d   = romWdata_q;
    romWe_d      = 1'b0;
    err_d        = err_q;
    cycleCount_d = cycleCount_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (accept) begin
          lenHi_d = bus.rx_data;
          state_d = ST_LEN_LO;
          if (state_q == ST_HALTED) cycleCount_d = '0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = newLen;
          if (lenBad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d     = 1'b0;
            wordIdx_d = '0;
            state_d   = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          dataHi_d = bus.rx_data;
          state_d  = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          romWe_d    = 1'b1;
          romWdata_d = {dataHi_q, bus.rx_data};
          romAddr_d  = wordIdx_q[ROM_AW-1:0];
          wordIdx_d  = wordNext;
          state_d    = lastWord ? ST_RUN : ST_DATA_HI;
        end
      end
      ST_RUN: begin
        if (cycleCount_q != '1) cycleCount_d = cycleCount_q + 32'd1;
        // A stop byte takes priority over a halt detected in the same cycle.
        if (accept && (bus.rx_data == STOP_BYTE)) state_d = ST_IDLE;
        else if (haltDet)                          state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
    haltClear  = (state_d == ST_RUN) && (state_q != ST_RUN);
    cpuReset_d = (state_d != ST_RUN);
    halted_d   = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lenHi_q      <= '0;
      len_q        <= '0;
      dataHi_q     <= '0;
      wordIdx_q    <= '0;
      romAddr_q    <= '0;
      romWdata_q   <= '0;
      romWe_q      <= 1'b0;
      cpuReset_q   <= 1'b1;
      err_q        <= 1'b0;
      halted_q     <= 1'b0;
      cycleCount_q <= '0;
    end else begin
      state_q      <= state_d;
      lenHi_q      <= lenHi_d;
      len_q        <= len_d;
      dataHi_q     <= dataHi_d;
      wordIdx_q    <= wordIdx_d;
      romAddr_q    <= romAddr_d;
      romWdata_q   <= romWdata_d;
      romWe_q      <= romWe_d;
      cpuReset_q   <= cpuReset_d;
      err_q        <= err_d;
      halted_q     <= halted_d;
      cycleCount_q <= cycleCount_d;
    end
  end

  assign bus.rom_addr  = romAddr_q;
  assign bus.rom_wdata = romWdata_q;
  assign bus.rom_we    = romWe_q;
  assign bus.cpu_reset = cpuReset_q;
  assign busy          = (state_q == ST_LEN_LO) || (state_q == ST_DATA_HI) ||
                         (state_q == ST_DATA_LO) || (state_q == ST_RUN);
  assign halted        = halted_q;
  assign err           = err_q;
  assign cycle_count   = cycleCount_q;

endmodule
